regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised general-purpose register file for the minimal RV32E MCU core with two asynchronous read ports, one clocked write port with byte strobes, and a per-register pending scoreboard. The scoreboard lets the core mark a destination register "in flight" when a multi-cycle load or peripheral access issues, then stall dependent instructions until write-back. It sits between decode (read ports and busy flags) and the write-back/load unit (write port and pending set).

## Interface
- `WIDTH`, default 32: register width in bits; must be a multiple of 8.
- `DEPTH`, default 16: number of registers; power of two, 2..32 (16 for RV32E, 32 for RV32I).
- `ZERO_REG`, default 1: when 1, register 0 reads as zero, ignores writes and is never pending.
- Localparam `ADDR_W = $clog2(DEPTH)`; localparam `NBYTE = WIDTH/8`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe, sampled at the rising edge of `clk`.
- `wr_addr`  in  ADDR_W  write register index.
- `wr_data`  in  WIDTH  write data.
- `wr_strb`  in  NBYTE  byte-lane enables; bit i covers `wr_data[8i+7:8i]`.
- `pend_set`  in  1  mark `pend_addr` pending at the next edge.
- `pend_addr`  in  ADDR_W  register to mark pending.
- `rd_addr1`, `rd_addr2`  in  ADDR_W  read indices.
- `rd_data1`, `rd_data2`  out  WIDTH  read data, combinational.
- `busy1`, `busy2`  out  1  pending flag of the addressed register, combinational.
- `any_pending`  out  1  OR of all pending bits, registered state.

## Operation
- Storage: DEPTH x WIDTH array plus DEPTH-bit pending vector.
- Reset: while `rst` is high, all registers = 0 and all pending bits = 0, immediately and independent of `clk`. All outputs therefore read 0 during reset. Reset mid-operation discards any in-flight write or pending set.
- Write: at a rising edge with `wr_en`=1, each lane i with `wr_strb[i]`=1 is updated; other lanes hold. `wr_strb`=0 performs no data change but still clears pending.
- Write to index 0 with `ZERO_REG`=1: data discarded, nothing changes.
- Pending: at an edge, `pend_set`=1 sets bit `pend_addr`; `wr_en`=1 clears bit `wr_addr`. If both target the same index in one cycle, set wins (new load issued as the old one retires). Different indices: both take effect.
- `pend_set` on an already pending register: stays pending, no error.
- Read: `rd_dataN` = array[`rd_addrN`]; 0 when `rd_addrN`=0 and `ZERO_REG`=1. `busyN` = pending[`rd_addrN`]. Both ports fully independent; same address on both returns identical values.

## Timing
- Read latency: 0 cycles (combinational from address and state).
- Write latency: data visible on read ports the cycle after the write edge (without bypass).
- Pending latency: `busyN` and `any_pending` assert the cycle after the `pend_set` edge and deassert the cycle after the clearing write edge.
- No handshake: the core must hold a dependent instruction while `busyN`=1; the block never back-pressures writes.

## Configuration
- `REGFILE_BYPASS_EN` defined: when `wr_en`=1 and `wr_addr`=`rd_addrN` (and not a zero-register write), `rd_dataN` returns the merged value (strobed lanes from `wr_data`, others from array) and `busyN`=0 in the same cycle, unless `pend_set` targets the same index, in which case `busyN` stays 1. Adds a combinational path `wr_*`->`rd_*`.
- Not defined: read ports and busy flags reflect stored state only; new data and cleared busy appear one cycle after the edge.

## Test plan
- Reset: assert `rst` mid-write with registers loaded -> all `rd_data`=0, `busy`=0, `any_pending`=0 immediately, no edge needed.
- Full write: write 0xDEADBEEF to r5, strb=0xF -> next cycle `rd_data1` (addr 5) = 0xDEADBEEF; write to r0 0x12345678 -> `rd_data2` (addr 0) = 0.
- Byte strobe: r5=0xDEADBEEF, write 0x000000AA strb=0x1 -> r5=0xDEADBEAA; strb=0x0 -> unchanged.
- Scoreboard: `pend_set` r7 -> `busy1`=1, `any_pending`=1 next cycle; write r7 0x55 -> `busy1`=0, data 0x55 next cycle; simultaneous `pend_set` r7 and write r7 -> data updated, `busy1` stays 1.
- Bypass (macro defined): r3=0x11111111, same cycle write 0x22222222 strb=0xF with `rd_addr1`=3 -> `rd_data1`=0x22222222 before the edge; macro undefined -> 0x11111111 until after the edge.
- Parameters: WIDTH=16, DEPTH=32, ZERO_REG=0 -> r0 writable and pendable, r31 read/write correct, strobe width 2.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, a byte-strobed write port and a
// per-register pending scoreboard. Optional same-cycle write bypass: REGFILE_BYPASS_EN.

module regfile_byte_lane (
  input  logic       en,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] out_byte
);
  assign out_byte = en ? new_byte : old_byte;
endmodule

module regfile_scoreboard #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 16,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int NBYTE    = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [NBYTE-1:0]  wr_strb,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              busy1,
  output logic              busy2,
  output logic              any_pending
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            pend_q, pend_d;
  logic [WIDTH-1:0]            wr_old, wr_merged;
  logic                        wr_ok, pend_ok;

  // r0 (when hardwired) swallows both writes and pending sets.
  assign wr_ok   = wr_en    && !((ZERO_REG != 0) && (wr_addr   == '0));
  assign pend_ok = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));
  assign wr_old  = regs_q[wr_addr];

  for (genvar i = 0; i < NBYTE; i++) begin : g_lane
    regfile_byte_lane u_lane (
      .en       (wr_strb[i]),
      .old_byte (wr_old[8*i +: 8]),
      .new_byte (wr_data[8*i +: 8]),
      .out_byte (wr_merged[8*i +: 8])
    );
  end

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_merged;
      pend_d[wr_addr] = 1'b0;
    end
    // Set after clear so a new load issued as the old one retires stays pending.
    if (pend_ok) pend_d[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    rd_data2 = regs_q[rd_addr2];
    busy1    = pend_q[rd_addr1];
    busy2    = pend_q[rd_addr2];
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_data1 = '0;
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) rd_data2 = '0;
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; held off during reset so outputs stay zero.
    if (wr_ok && !rst && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_merged;
      busy1    = pend_ok && (pend_addr == rd_addr1);
    end
    if (wr_ok && !rst && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_merged;
      busy2    = pend_ok && (pend_addr == rd_addr2);
    end
`endif
  end

  assign any_pending = |pend_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default instance plus a WIDTH=16/DEPTH=32/ZERO_REG=0 instance.

module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // default instance
  logic        a_wr_en, a_pend_set;
  logic [3:0]  a_wr_addr, a_pend_addr, a_rd_addr1, a_rd_addr2;
  logic [31:0] a_wr_data, a_rd_data1, a_rd_data2;
  logic [3:0]  a_wr_strb;
  logic        a_busy1, a_busy2, a_any;

  regfile_scoreboard u_a (
    .clk(clk), .rst(rst),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_strb(a_wr_strb),
    .pend_set(a_pend_set), .pend_addr(a_pend_addr),
    .rd_addr1(a_rd_addr1), .rd_addr2(a_rd_addr2),
    .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
    .busy1(a_busy1), .busy2(a_busy2), .any_pending(a_any)
  );

  // narrow/deep instance with writable r0
  logic        b_wr_en, b_pend_set;
  logic [4:0]  b_wr_addr, b_pend_addr, b_rd_addr1, b_rd_addr2;
  logic [15:0] b_wr_data, b_rd_data1, b_rd_data2;
  logic [1:0]  b_wr_strb;
  logic        b_busy1, b_busy2, b_any;

  regfile_scoreboard #(.WIDTH(16), .DEPTH(32), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_strb(b_wr_strb),
    .pend_set(b_pend_set), .pend_addr(b_pend_addr),
    .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .busy1(b_busy1), .busy2(b_busy2), .any_pending(b_any)
  );

  task automatic clear_inputs();
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_wr_strb = 0; a_pend_set = 0; a_pend_addr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_strb = 0; b_pend_set = 0; b_pend_addr = 0;
  endtask

  // Advance one edge, drop write/pend strobes, let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
  endtask

  task automatic a_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    a_wr_en = 1; a_wr_addr = addr; a_wr_data = data; a_wr_strb = strb;
    tick();
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if (a_rd_data1 !== 32'h0) $display("FAIL reset_rd_data1 got=%h exp=%h", a_rd_data1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (a_busy1 !== 1'b0 || a_busy2 !== 1'b0) $display("FAIL reset_busy got=%b%b exp=00", a_busy1, a_busy2);
    else pass_cnt++;
    total_cnt++;
    if (a_any !== 1'b0 || b_any !== 1'b0) $display("FAIL reset_any_pending got=%b%b exp=00", a_any, b_any);
    else pass_cnt++;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_write();
    a_rd_addr1 = 5; a_rd_addr2 = 0;
    a_write(5, 32'hDEADBEEF, 4'hF);
    total_cnt++;
    if (a_rd_data1 !== 32'hDEADBEEF) $display("FAIL full_write_r5 got=%h exp=%h", a_rd_data1, 32'hDEADBEEF);
    else pass_cnt++;
    a_write(0, 32'h12345678, 4'hF);
    total_cnt++;
    if (a_rd_data2 !== 32'h0) $display("FAIL zero_reg_read got=%h exp=%h", a_rd_data2, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_byte_strobe();
    a_rd_addr1 = 5;
    a_write(5, 32'h000000AA, 4'h1);
    total_cnt++;
    if (a_rd_data1 !== 32'hDEADBEAA) $display("FAIL strb_lane0 got=%h exp=%h", a_rd_data1, 32'hDEADBEAA);
    else pass_cnt++;
    a_write(5, 32'hFFFFFFFF, 4'h0);
    total_cnt++;
    if (a_rd_data1 !== 32'hDEADBEAA) $display("FAIL strb_none got=%h exp=%h", a_rd_data1, 32'hDEADBEAA);
    else pass_cnt++;
    a_write(5, 32'h12340000, 4'hC);
    total_cnt++;
    if (a_rd_data1 !== 32'h1234BEAA) $display("FAIL strb_upper got=%h exp=%h", a_rd_data1, 32'h1234BEAA);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    a_rd_addr1 = 7; a_rd_addr2 = 5;
    a_pend_set = 1; a_pend_addr = 7;
    tick();
    total_cnt++;
    if (a_busy1 !== 1'b1 || a_any !== 1'b1 || a_busy2 !== 1'b0)
      $display("FAIL pend_set got=busy1:%b any:%b busy2:%b exp=1 1 0", a_busy1, a_any, a_busy2);
    else pass_cnt++;
    a_write(7, 32'h55, 4'hF);
    total_cnt++;
    if (a_busy1 !== 1'b0 || a_any !== 1'b0 || a_rd_data1 !== 32'h55)
      $display("FAIL pend_clear got=busy1:%b any:%b data:%h exp=0 0 00000055", a_busy1, a_any, a_rd_data1);
    else pass_cnt++;
    a_pend_set = 1; a_pend_addr = 7;
    a_write(7, 32'h66, 4'hF);
    total_cnt++;
    if (a_busy1 !== 1'b1 || a_rd_data1 !== 32'h66)
      $display("FAIL set_wins got=busy1:%b data:%h exp=1 00000066", a_busy1, a_rd_data1);
    else pass_cnt++;
    a_pend_set = 1; a_pend_addr = 7;
    tick();
    total_cnt++;
    if (a_busy1 !== 1'b1 || a_any !== 1'b1) $display("FAIL re_pend got=busy1:%b any:%b exp=1 1", a_busy1, a_any);
    else pass_cnt++;
    a_rd_addr2 = 9;
    a_pend_set = 1; a_pend_addr = 9;
    a_write(7, 32'h77, 4'hF);
    total_cnt++;
    if (a_busy1 !== 1'b0 || a_busy2 !== 1'b1 || a_any !== 1'b1)
      $display("FAIL set_clear_split got=busy1:%b busy2:%b any:%b exp=0 1 1", a_busy1, a_busy2, a_any);
    else pass_cnt++;
    a_write(9, 32'hFFFFFFFF, 4'h0);
    total_cnt++;
    if (a_busy2 !== 1'b0 || a_any !== 1'b0 || a_rd_data2 !== 32'h0)
      $display("FAIL strb0_clears got=busy2:%b any:%b data:%h exp=0 0 00000000", a_busy2, a_any, a_rd_data2);
    else pass_cnt++;
    a_rd_addr1 = 0;
    a_pend_set = 1; a_pend_addr = 0;
    tick();
    total_cnt++;
    if (a_busy1 !== 1'b0 || a_any !== 1'b0) $display("FAIL r0_never_pending got=busy1:%b any:%b exp=0 0", a_busy1, a_any);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    a_rd_addr1 = 3; a_rd_addr2 = 3;
    a_write(3, 32'h11111111, 4'hF);
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'h22222222; a_wr_strb = 4'hF;
    #1;
    total_cnt++;
    if (a_rd_data1 !== (BYP ? 32'h22222222 : 32'h11111111))
      $display("FAIL bypass_full got=%h exp=%h", a_rd_data1, BYP ? 32'h22222222 : 32'h11111111);
    else pass_cnt++;
    a_wr_data = 32'h000000AA; a_wr_strb = 4'h1;
    #1;
    total_cnt++;
    if (a_rd_data2 !== (BYP ? 32'h111111AA : 32'h11111111) || a_rd_data1 !== a_rd_data2)
      $display("FAIL bypass_merge got=%h/%h exp=%h", a_rd_data1, a_rd_data2, BYP ? 32'h111111AA : 32'h11111111);
    else pass_cnt++;
    a_wr_data = 32'h22222222; a_wr_strb = 4'hF;
    tick();
    total_cnt++;
    if (a_rd_data1 !== 32'h22222222) $display("FAIL bypass_after_edge got=%h exp=%h", a_rd_data1, 32'h22222222);
    else pass_cnt++;
    a_pend_set = 1; a_pend_addr = 3;
    tick();
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'h33333333; a_wr_strb = 4'hF;
    #1;
    total_cnt++;
    if (a_busy1 !== !BYP) $display("FAIL bypass_busy got=%b exp=%b", a_busy1, !BYP);
    else pass_cnt++;
    a_pend_set = 1; a_pend_addr = 3;
    #1;
    total_cnt++;
    if (a_busy1 !== 1'b1) $display("FAIL bypass_busy_set_wins got=%b exp=1", a_busy1);
    else pass_cnt++;
    tick();
    a_write(3, 32'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    a_rd_addr1 = 5; a_rd_addr2 = 4;
    a_pend_set = 1; a_pend_addr = 4;
    tick();
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'hCAFEF00D; a_wr_strb = 4'hF;
    #2;
    rst = 1;
    #1;
    total_cnt++;
    if (a_rd_data1 !== 32'h0 || a_busy2 !== 1'b0 || a_any !== 1'b0)
      $display("FAIL reset_mid got=data:%h busy2:%b any:%b exp=00000000 0 0", a_rd_data1, a_busy2, a_any);
    else pass_cnt++;
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 0;
    tick();
    total_cnt++;
    if (a_rd_data1 !== 32'h0 || a_busy2 !== 1'b0) $display("FAIL reset_discard got=data:%h busy2:%b exp=0 0", a_rd_data1, a_busy2);
    else pass_cnt++;
  endtask

  task automatic test_params();
    b_rd_addr1 = 0; b_rd_addr2 = 31;
    b_wr_en = 1; b_wr_addr = 0; b_wr_data = 16'hBEEF; b_wr_strb = 2'b11;
    b_pend_set = 1; b_pend_addr = 0;
    tick();
    total_cnt++;
    if (b_rd_data1 !== 16'hBEEF || b_busy1 !== 1'b1 || b_any !== 1'b1)
      $display("FAIL param_r0 got=data:%h busy1:%b any:%b exp=beef 1 1", b_rd_data1, b_busy1, b_any);
    else pass_cnt++;
    b_wr_en = 1; b_wr_addr = 31; b_wr_data = 16'h1234; b_wr_strb = 2'b11;
    tick();
    b_wr_en = 1; b_wr_addr = 31; b_wr_data = 16'hAB00; b_wr_strb = 2'b10;
    tick();
    total_cnt++;
    if (b_rd_data2 !== 16'hAB34) $display("FAIL param_r31_strb got=%h exp=%h", b_rd_data2, 16'hAB34);
    else pass_cnt++;
    b_wr_en = 1; b_wr_addr = 0; b_wr_data = 16'h0; b_wr_strb = 2'b00;
    tick();
    total_cnt++;
    if (b_rd_data1 !== 16'hBEEF || b_busy1 !== 1'b0 || b_any !== 1'b0)
      $display("FAIL param_r0_clear got=data:%h busy1:%b any:%b exp=beef 0 0", b_rd_data1, b_busy1, b_any);
    else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    a_rd_addr1 = 5; a_rd_addr2 = 0; b_rd_addr1 = 0; b_rd_addr2 = 0;
    test_reset();
    test_full_write();
    test_byte_strobe();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    test_params();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
